// File: rtl/comb_pkg.sv
// Shared types and Q-format constants for the reverb comb stage.
// Default WIDTH/COEF_WIDTH match the stage defaults; clamp helpers serve any width.
package comb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DAMP_A = 3'd1,
        DAMP_B = 3'd2,
        FB     = 3'd3,
        SUM    = 3'd4
    } comb_state_t;

    localparam int DEF_WIDTH      = 24;
    localparam int DEF_COEF_WIDTH = 16;
    localparam int Q_SHIFT        = DEF_COEF_WIDTH - 1;

    function automatic logic signed [63:0] clamp_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] clamp_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/reverb_comb_stage_sat_trunc.sv
// Arithmetic right shift of a wide accumulator down to OUT_WIDTH.
// With COMB_SATURATE_EN defined the result is clamped and sat flags the clamp; otherwise it wraps.
module sat_trunc
    import comb_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_WIDTH + DEF_COEF_WIDTH + 1,
    parameter int OUT_WIDTH = DEF_WIDTH,
    parameter int SHIFT     = Q_SHIFT
) (
    input  logic [IN_WIDTH-1:0]  acc,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 sat
);

    localparam int HI_WIDTH = IN_WIDTH - OUT_WIDTH - SHIFT + 1;

    logic [OUT_WIDTH-1:0] trunc_s;
    logic [HI_WIDTH-1:0]  hi_s;
    logic                 unused_low_s;

    // Slicing after the shift point is exactly an arithmetic shift plus truncation (floor).
    assign trunc_s      = acc[OUT_WIDTH+SHIFT-1:SHIFT];
    assign hi_s         = acc[IN_WIDTH-1:OUT_WIDTH+SHIFT-1];
    assign unused_low_s = ^acc[SHIFT-1:0];

`ifdef COMB_SATURATE_EN
    localparam logic [OUT_WIDTH-1:0] MAX_V = OUT_WIDTH'(clamp_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] MIN_V = OUT_WIDTH'(clamp_min(OUT_WIDTH));

    // Clamp whenever the discarded high bits are not a pure sign extension.
    always_comb begin
        if ((&hi_s) || (~|hi_s)) begin
            result = trunc_s;
            sat    = 1'b0;
        end else if (acc[IN_WIDTH-1]) begin
            result = MIN_V;
            sat    = 1'b1;
        end else begin
            result = MAX_V;
            sat    = 1'b1;
        end
    end
`else
    logic unused_hi_s;

    assign unused_hi_s = ^hi_s;
    assign result      = trunc_s;
    assign sat         = 1'b0;
`endif

endmodule

// File: rtl/reverb_comb_stage.sv
// Damped feedback comb around a reverb delay line, one shared multiplier over a 5-state pass.
// Optional clamping of the store update and output sum via COMB_SATURATE_EN.
module reverb_comb_stage
    import comb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_valid,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic [WIDTH-1:0]      delayed_in,
    input  logic [COEF_WIDTH-1:0] feedback,
    input  logic [COEF_WIDTH-1:0] damp,
    input  logic                  clear_state,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      sample_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  sat_flag
);

    localparam int QS = COEF_WIDTH - 1;
    localparam int PW = WIDTH + COEF_WIDTH + 1;
    localparam int BW = COEF_WIDTH + 1;
    localparam logic [BW-1:0] UNITY = {2'b01, {QS{1'b0}}};
`ifdef COMB_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    comb_state_t state_r, next_state_s;

    logic signed [WIDTH-1:0] x_r, d_r, store_r, wr_data_r, sample_out_r;
    logic signed [PW-1:0]    acc_r, prod_s, store_acc_s, sum_acc_s;
    logic signed [WIDTH-1:0] mul_a_s;
    logic signed [BW-1:0]    mul_b_s, omd_s;
    logic [WIDTH-1:0]        store_next_s, sum_next_s;
    logic                    store_sat_s, sum_sat_s;
    logic                    ld_sample_s, ld_acc_s, ld_store_s, ld_out_s, pass_done_s;
    logic                    wr_en_r, out_valid_r, busy_r, overrun_r, sat_r, clr_pend_r;

    assign omd_s       = UNITY - {1'b0, damp};
    assign prod_s      = PW'(mul_a_s) * PW'(mul_b_s);
    assign store_acc_s = acc_r + prod_s;
    // x is pre-scaled so the final shift floors only the feedback product.
    assign sum_acc_s   = (PW'(x_r) <<< QS) + prod_s;

    sat_trunc #(.IN_WIDTH(PW), .OUT_WIDTH(WIDTH), .SHIFT(QS)) u_store_trunc (
        .acc    (store_acc_s),
        .result (store_next_s),
        .sat    (store_sat_s)
    );

    sat_trunc #(.IN_WIDTH(PW), .OUT_WIDTH(WIDTH), .SHIFT(QS)) u_sum_trunc (
        .acc    (sum_acc_s),
        .result (sum_next_s),
        .sat    (sum_sat_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a fixed walk through the pass once a sample is accepted.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE:    next_state_s = sample_valid ? DAMP_A : IDLE;
            DAMP_A:  next_state_s = DAMP_B;
            DAMP_B:  next_state_s = FB;
            FB:      next_state_s = SUM;
            SUM:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Per-state datapath controls and multiplier operand selection.
    always_comb begin
        ld_sample_s = 1'b0;
        ld_acc_s    = 1'b0;
        ld_store_s  = 1'b0;
        ld_out_s    = 1'b0;
        pass_done_s = 1'b0;
        mul_a_s     = {WIDTH{1'b0}};
        mul_b_s     = {BW{1'b0}};
        case (state_r)
            IDLE: ld_sample_s = sample_valid;
            DAMP_A: begin
                ld_acc_s = 1'b1;
                mul_a_s  = d_r;
                mul_b_s  = omd_s;
            end
            DAMP_B: begin
                ld_store_s = 1'b1;
                mul_a_s    = store_r;
                mul_b_s    = {damp[COEF_WIDTH-1], damp};
            end
            FB: begin
                ld_out_s = 1'b1;
                mul_a_s  = store_r;
                mul_b_s  = {feedback[COEF_WIDTH-1], feedback};
            end
            SUM:     pass_done_s = 1'b1;
            default: pass_done_s = 1'b0;
        endcase
    end

    // Datapath, filter store and registered outputs; strobes launch from FB so they show during SUM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_r          <= {WIDTH{1'b0}};
            d_r          <= {WIDTH{1'b0}};
            acc_r        <= {PW{1'b0}};
            store_r      <= {WIDTH{1'b0}};
            clr_pend_r   <= 1'b0;
            wr_data_r    <= {WIDTH{1'b0}};
            sample_out_r <= {WIDTH{1'b0}};
            wr_en_r      <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            sat_r        <= 1'b0;
        end else begin
            if (ld_sample_s) begin
                x_r <= sample_in;
                d_r <= delayed_in;
            end
            if (ld_acc_s) begin
                acc_r <= prod_s;
            end
            if ((state_r == IDLE) && clear_state) begin
                store_r <= {WIDTH{1'b0}};
            end else if (ld_store_s) begin
                store_r <= store_next_s;
            end else if (pass_done_s && (clear_state || clr_pend_r)) begin
                store_r <= {WIDTH{1'b0}};
            end
            // A clear seen mid-pass is deferred until the pass finishes.
            if ((state_r == IDLE) || pass_done_s) begin
                clr_pend_r <= 1'b0;
            end else if (clear_state) begin
                clr_pend_r <= 1'b1;
            end
            wr_en_r     <= ld_out_s;
            out_valid_r <= ld_out_s;
            if (ld_out_s) begin
                wr_data_r    <= sum_next_s;
                sample_out_r <= d_r;
            end
            busy_r <= (next_state_s != IDLE);
            if (sample_valid && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (SAT_EN && ((ld_store_s && store_sat_s) || (ld_out_s && sum_sat_s))) begin
                sat_r <= 1'b1;
            end
        end
    end

    assign wr_data    = wr_data_r;
    assign wr_en      = wr_en_r;
    assign sample_out = sample_out_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;
    assign sat_flag   = sat_r;

endmodule

// File: tb/tb_reverb_comb_stage.sv
// Directed self-checking bench for reverb_comb_stage; expected values are hand-computed Q1.15 results.
// Sat expectations follow COMB_SATURATE_EN.
module tb_reverb_comb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sample_valid;
    logic [23:0] sample_in;
    logic [23:0] delayed_in;
    logic [15:0] feedback;
    logic [15:0] damp;
    logic        clear_state;
    logic [23:0] wr_data;
    logic        wr_en;
    logic [23:0] sample_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;

    reverb_comb_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .delayed_in   (delayed_in),
        .feedback     (feedback),
        .damp         (damp),
        .clear_state  (clear_state),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    // Issues one sample and watches 8 cycles: captures the wr_en pulse, its cycle offset and strobe alignment.
    task automatic run_sample(input logic [23:0] x, input logic [23:0] d, input logic [15:0] fb,
                              input logic [15:0] dm, input logic clr,
                              output logic [23:0] wr, output logic [23:0] so,
                              output int lat, output int pulses, output int ov_bad);
        @(negedge clk);
        sample_in = x; delayed_in = d; feedback = fb; damp = dm;
        clear_state = clr; sample_valid = 1'b1;
        lat = 0; pulses = 0; ov_bad = 0; wr = 24'h0; so = 24'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                sample_valid = 1'b0;
                clear_state  = 1'b0;
            end
            if (wr_en === 1'b1) begin
                pulses++;
                lat = k;
                wr  = wr_data;
                so  = sample_out;
            end
            if (out_valid !== wr_en) ov_bad++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if ({wr_data, sample_out, wr_en, out_valid, busy, overrun, sat_flag} !== 55'h0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%h so=%h en=%b ov=%b busy=%b orun=%b sat=%b exp all 0",
                     wr_data, sample_out, wr_en, out_valid, busy, overrun, sat_flag);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [23:0] wr, so;
        int lat, p, ovb;
        run_sample(24'h000100, 24'h000000, 16'h4000, 16'h0000, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000100) begin errors++; $display("FAIL basic_wr got %h exp 000100", wr); end
        checks++;
        if (so !== 24'h000000) begin errors++; $display("FAIL basic_so got %h exp 000000", so); end
        checks++;
        if (lat !== 4 || p !== 1) begin errors++; $display("FAIL basic_latency got lat=%0d pulses=%0d exp 4/1", lat, p); end
        checks++;
        if (ovb !== 0) begin errors++; $display("FAIL basic_out_valid got %0d misaligned cycles exp 0", ovb); end
        checks++;
        if (wr_data !== 24'h000100) begin errors++; $display("FAIL basic_hold got %h exp 000100", wr_data); end
    endtask

    task automatic test_damping();
        logic [23:0] wr, so;
        int lat, p, ovb;
        run_sample(24'h000000, 24'h000200, 16'h4000, 16'h0000, 1'b1, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000100 || so !== 24'h000200) begin
            errors++; $display("FAIL damp0_fb_half got wr=%h so=%h exp 000100/000200", wr, so);
        end
        run_sample(24'h000000, 24'h000200, 16'h4000, 16'h4000, 1'b1, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000080) begin errors++; $display("FAIL damp_half got %h exp 000080", wr); end
        // store now 0x100: next pass with d=0 gives store 0x80, wr 0x40
        run_sample(24'h000000, 24'h000000, 16'h4000, 16'h4000, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000040) begin errors++; $display("FAIL damp_store_carry got %h exp 000040", wr); end
        run_sample(24'h000000, 24'hFFFFFF, 16'h4000, 16'h0000, 1'b1, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'hFFFFFF || so !== 24'hFFFFFF) begin
            errors++; $display("FAIL negative_floor got wr=%h so=%h exp FFFFFF/FFFFFF", wr, so);
        end
        run_sample(24'h123456, 24'h000200, 16'h0000, 16'h1234, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h123456) begin errors++; $display("FAIL feedback_zero got %h exp 123456", wr); end
    endtask

    task automatic test_clear();
        logic [23:0] wr, so;
        int lat, p, ovb;
        run_sample(24'h000000, 24'h000200, 16'h4000, 16'h0000, 1'b1, wr, so, lat, p, ovb);
        run_sample(24'h000123, 24'h000000, 16'h4000, 16'h4000, 1'b1, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000123) begin errors++; $display("FAIL clear_with_sample got %h exp 000123", wr); end
        run_sample(24'h000000, 24'h000200, 16'h4000, 16'h0000, 1'b1, wr, so, lat, p, ovb);
        run_sample(24'h000123, 24'h000000, 16'h4000, 16'h4000, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h0001A3) begin errors++; $display("FAIL no_clear_ref got %h exp 0001A3", wr); end
        @(negedge clk); clear_state = 1'b1;
        @(negedge clk); clear_state = 1'b0;
        run_sample(24'h000000, 24'h000000, 16'h4000, 16'h4000, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000000) begin errors++; $display("FAIL clear_idle got %h exp 000000", wr); end
        // clear during the pass must not disturb it, only zero the store afterwards
        run_sample(24'h000000, 24'h000200, 16'h4000, 16'h0000, 1'b1, wr, so, lat, p, ovb);
        @(negedge clk);
        sample_in = 24'h0; delayed_in = 24'h0; damp = 16'h4000; sample_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) sample_valid = 1'b0;
            if (k == 2) clear_state = 1'b1;
            if (k == 3) clear_state = 1'b0;
            checks++;
            if (busy !== (k <= 4)) begin errors++; $display("FAIL busy_window k=%0d got %b exp %b", k, busy, (k <= 4)); end
            if (k == 4) begin
                checks++;
                if (wr_en !== 1'b1 || wr_data !== 24'h000080) begin
                    errors++; $display("FAIL clear_busy_pass got en=%b wr=%h exp 1/000080", wr_en, wr_data);
                end
            end
        end
        run_sample(24'h000000, 24'h000000, 16'h4000, 16'h4000, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000000) begin errors++; $display("FAIL clear_busy_after got %h exp 000000", wr); end
    endtask

    task automatic test_overrun();
        logic [23:0] wr, so;
        int lat = 0, p = 0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got %b exp 0", overrun); end
        @(negedge clk);
        sample_in = 24'h000100; delayed_in = 24'h000200; feedback = 16'h4000; damp = 16'h0000;
        clear_state = 1'b1; sample_valid = 1'b1;
        wr = 24'h0; so = 24'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin sample_valid = 1'b0; clear_state = 1'b0; end
            if (k == 2) begin sample_in = 24'h000555; delayed_in = 24'h000666; sample_valid = 1'b1; end
            if (k == 3) sample_valid = 1'b0;
            if (wr_en === 1'b1) begin p++; lat = k; wr = wr_data; so = sample_out; end
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", overrun); end
        checks++;
        if (p !== 1 || lat !== 4) begin errors++; $display("FAIL overrun_pulses got pulses=%0d lat=%0d exp 1/4", p, lat); end
        checks++;
        if (wr !== 24'h000200 || so !== 24'h000200) begin
            errors++; $display("FAIL overrun_result got wr=%h so=%h exp 000200/000200", wr, so);
        end
    endtask

    task automatic test_sat();
        logic [23:0] wr, so;
        int lat, p, ovb;
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_initial got %b exp 0", sat_flag); end
        run_sample(24'h7FFFFF, 24'h7FFFFF, 16'h7FFF, 16'h0000, 1'b1, wr, so, lat, p, ovb);
`ifdef COMB_SATURATE_EN
        checks++;
        if (wr !== 24'h7FFFFF || sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_clamp got wr=%h sat=%b exp 7FFFFF/1", wr, sat_flag);
        end
`else
        checks++;
        if (wr !== 24'hFFFEFE || sat_flag !== 1'b0) begin
            errors++; $display("FAIL sat_wrap got wr=%h sat=%b exp FFFEFE/0", wr, sat_flag);
        end
`endif
        checks++;
        if (so !== 24'h7FFFFF) begin errors++; $display("FAIL sat_so got %h exp 7FFFFF", so); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] wr, so;
        int lat, p = 0, ovb;
        @(negedge clk);
        sample_in = 24'h000100; delayed_in = 24'h000300; feedback = 16'h4000; damp = 16'h0000;
        sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({wr_data, sample_out, wr_en, out_valid, busy, overrun, sat_flag} !== 55'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got wr=%h so=%h en=%b ov=%b busy=%b orun=%b sat=%b exp all 0",
                     wr_data, sample_out, wr_en, out_valid, busy, overrun, sat_flag);
        end
        @(negedge clk); rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || busy !== 1'b0) p++;
        end
        checks++;
        if (p !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", p); end
        run_sample(24'h000100, 24'h000000, 16'h4000, 16'h0000, 1'b0, wr, so, lat, p, ovb);
        checks++;
        if (wr !== 24'h000100 || lat !== 4) begin
            errors++; $display("FAIL reset_mid_resume got wr=%h lat=%0d exp 000100/4", wr, lat);
        end
    endtask

    initial begin
        rstn = 1'b0; sample_valid = 1'b0; clear_state = 1'b0;
        sample_in = 24'h0; delayed_in = 24'h0; feedback = 16'h0; damp = 16'h0;
        test_reset();
        test_basic();
        test_damping();
        test_clear();
        test_overrun();
        test_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reverb_comb_stage.md
Name: reverb_comb_stage

Overview:
Feedback comb filter with damping, the stage that wraps the reverb delay line.
- Consumes the delayed sample read from the delay line.
- Computes the new write sample: input + feedback × lowpass(delayed).
- Emits the delayed sample as the stage output.
- Uses one shared multiplier, sequenced by an FSM at one pass per audio sample.

Parameters:
WIDTH, 24, signed audio sample width (two's complement).
COEF_WIDTH, 16, signed coefficient width, Q1.(COEF_WIDTH-1) format.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
sample_valid  in  1  one-clk strobe per audio sample
sample_in  in  WIDTH  dry input sample
delayed_in  in  WIDTH  current delay-line output
feedback  in  COEF_WIDTH  feedback gain, 0..2^(COEF_WIDTH-1)-1
damp  in  COEF_WIDTH  damping coefficient, 0..2^(COEF_WIDTH-1)-1
clear_state  in  1  synchronous clear of the damping filter state
wr_data  out  WIDTH  sample to write into the delay line
wr_en  out  1  one-clk write strobe to the delay line
sample_out  out  WIDTH  stage output (delayed sample)
out_valid  out  1  one-clk strobe, sample_out updated
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: sample_valid arrived while busy
sat_flag  out  1  sticky: saturation occurred (COMB_SATURATE_EN only)

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0, filter store 0, FSM to IDLE, sticky flags cleared.
- Reset mid-operation aborts the pass; no wr_en is issued.
- Q format:
  - coefficient 2^(COEF_WIDTH-1) represents 1.0.
  - one_minus_damp = 2^(COEF_WIDTH-1) - damp, held in COEF_WIDTH+1 bits.
  - Products are WIDTH+COEF_WIDTH+1 bits, arithmetic-shifted right by COEF_WIDTH-1 (truncation toward -inf).
- FSM states: IDLE, DAMP_A, DAMP_B, FB, SUM.
  - IDLE: on sample_valid, latch x = sample_in and d = delayed_in -> DAMP_A.
  - DAMP_A: acc = d × one_minus_damp.
  - DAMP_B: acc += store × damp; store <= acc >> (COEF_WIDTH-1).
  - FB: p = store × feedback >> (COEF_WIDTH-1).
  - SUM: wr_data <= x + p; sample_out <= d; pulse wr_en and out_valid for exactly one cycle -> IDLE.
- Latency:
  - sample_valid at cycle N -> wr_en and out_valid high at cycle N+4.
  - busy high cycles N+1..N+4.
  - Minimum sample spacing is 5 clks.
- sample_valid while busy: sample dropped, overrun set, current pass unaffected.
- clear_state:
  - In IDLE: sets store to 0.
  - Coincident with sample_valid: the sample is processed with store = 0.
  - While busy: takes effect after the pass, i.e. store is 0 on return to IDLE.
- wr_data, sample_out hold their values between strobes.
- feedback = 0: wr_data = sample_in exactly.
- damp = 0: store = d exactly.

Optional Feature:
COMB_SATURATE_EN.
- Defined:
  - The store update and x + p are clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Any clamp sets sat_flag (sticky until reset).
- Undefined:
  - Results wrap modulo 2^WIDTH.
  - sat_flag tied 0.

Decomposition:
- Package comb_pkg holds:
  - comb_state_t enum (IDLE, DAMP_A, DAMP_B, FB, SUM)
  - Q-format constant Q_SHIFT = COEF_WIDTH-1
  - helper constants for the clamp bounds
- Sub-module sat_trunc: shift + truncate/saturate of a wide accumulator to WIDTH, with sat output.
  - Instantiated twice: store update and final sum.
  - Its saturation path is compiled in/out by COMB_SATURATE_EN.

Test Plan:
- Reset, then sample_valid with sample_in=0x000100, delayed_in=0, feedback=0x4000, damp=0 -> wr_data=0x000100, sample_out=0, wr_en/out_valid exactly 4 clks after strobe.
- damp=0, feedback=0x4000 (0.5), delayed_in=0x000200, sample_in=0 -> wr_data=0x000100; damp=0x4000 with store=0, delayed_in=0x000200 -> store=0x000100, wr_data=0x000080.
- Second sample_valid 2 clks after first -> overrun=1, exactly one wr_en pulse, first result correct.
- With COMB_SATURATE_EN: sample_in=0x7FFFFF, delayed_in=0x7FFFFF, damp=0, feedback=0x7FFF -> wr_data=0x7FFFFF, sat_flag=1. Without the macro -> wrapped negative value, sat_flag=0.
- Load store nonzero, assert clear_state with sample_valid, delayed_in=0, damp=0x4000 -> wr_data=sample_in.
- Drop rstn at DAMP_B -> outputs 0 immediately; no wr_en after release until a new sample_valid.
